// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        StAllRed   = 3'd0,
        StNsLeft   = 3'd1,
        StNsGreen  = 3'd2,
        StNsYellow = 3'd3,
        StEwLeft   = 3'd4,
        StEwGreen  = 3'd5,
        StEwYellow = 3'd6,
        StEmStop   = 3'd7
    } state_e;

    typedef enum logic {
        ApprNs = 1'b0,
        ApprEw = 1'b1
    } approach_e;

    localparam logic [3:0] LampLeft   = 4'b1001;
    localparam logic [3:0] LampGreen  = 4'b0100;
    localparam logic [3:0] LampYellow = 4'b0010;
    localparam logic [3:0] LampRed    = 4'b0001;

    function automatic logic [3:0] ns_lamp(state_e s);
        case (s)
            StNsLeft:   return LampLeft;
            StNsGreen:  return LampGreen;
            StNsYellow: return LampYellow;
            default:    return LampRed;
        endcase
    endfunction

    function automatic logic [3:0] ew_lamp(state_e s);
        case (s)
            StEwLeft:   return LampLeft;
            StEwGreen:  return LampGreen;
            StEwYellow: return LampYellow;
            default:    return LampRed;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state cycle counter: cleared on state entry, saturates at 255, flags the last cycle.
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] len,
    output logic       done
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (clear) begin
            cnt_q <= 8'd0;
        end else if (cnt_q != 8'hff) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign done = (cnt_q == len - 8'd1);

endmodule

// File: rtl/intersection_controller.sv
// Single-FSM sequencer for a two-approach intersection with protected lefts,
// all-red clearance and emergency preemption.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int unsigned LEFT_T   = 5,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned CLEAR_T  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    input  logic       ns_left_req,
    input  logic       ew_left_req,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic       allstop,
    output logic [2:0] phase
);

    state_e    state_q, state_d;
    approach_e next_app_q, next_app_d;
    logic      ns_left_q, ns_left_d;
    logic      ew_left_q, ew_left_d;
    logic      em_latched_q, em_latched_d;
    logic [7:0] len;
    logic      done;
    logic      em_any;

    always_comb begin
        case (state_q)
            StAllRed:               len = 8'(CLEAR_T);
            StNsLeft, StEwLeft:     len = 8'(LEFT_T);
            StNsGreen, StEwGreen:   len = 8'(GREEN_T);
            StNsYellow, StEwYellow: len = 8'(YELLOW_T);
            default:                len = 8'd1;
        endcase
    end

    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state_d != state_q),
        .len   (len),
        .done  (done)
    );

    assign em_any = emergency | em_latched_q;

    always_comb begin
        state_d    = state_q;
        next_app_d = next_app_q;
        case (state_q)
            StAllRed: begin
                if (em_any) begin
                    state_d = StEmStop;
                end else if (done) begin
                    if (next_app_q == ApprNs) begin
                        state_d = (ns_left_q | ns_left_req) ? StNsLeft : StNsGreen;
                    end else begin
                        state_d = (ew_left_q | ew_left_req) ? StEwLeft : StEwGreen;
                    end
                end
            end
            StNsLeft:   if (em_any) state_d = StNsYellow; else if (done) state_d = StNsGreen;
            StNsGreen:  if (em_any || done) state_d = StNsYellow;
            StNsYellow: begin
                if (done) begin
                    state_d    = em_any ? StEmStop : StAllRed;
                    next_app_d = ApprEw;
                end
            end
            StEwLeft:   if (em_any) state_d = StEwYellow; else if (done) state_d = StEwGreen;
            StEwGreen:  if (em_any || done) state_d = StEwYellow;
            StEwYellow: begin
                if (done) begin
                    state_d    = em_any ? StEmStop : StAllRed;
                    next_app_d = ApprNs;
                end
            end
            StEmStop:   if (!emergency) state_d = StAllRed;
            default:    state_d = StAllRed;
        endcase
    end

    // Entry into a left phase consumes the flag, even if a request coincides with that edge.
    always_comb begin
        ns_left_d = (state_d == StNsLeft && state_q != StNsLeft) ? 1'b0 : (ns_left_q | ns_left_req);
        ew_left_d = (state_d == StEwLeft && state_q != StEwLeft) ? 1'b0 : (ew_left_q | ew_left_req);
        if (state_d == StEmStop && state_q != StEmStop) begin
            em_latched_d = 1'b0;
        end else if (state_q != StEmStop && emergency) begin
            em_latched_d = 1'b1;
        end else begin
            em_latched_d = em_latched_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StAllRed;
            next_app_q   <= ApprNs;
            ns_left_q    <= 1'b0;
            ew_left_q    <= 1'b0;
            em_latched_q <= 1'b0;
            ns_out       <= LampRed;
            ew_out       <= LampRed;
            allstop      <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_app_q   <= next_app_d;
            ns_left_q    <= ns_left_d;
            ew_left_q    <= ew_left_d;
            em_latched_q <= em_latched_d;
            ns_out       <= ns_lamp(state_d);
            ew_out       <= ew_lamp(state_d);
            allstop      <= (state_d == StEmStop);
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed scenarios with a scoreboard queue of expected phases, checked by a negedge monitor.
module tb_intersection_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       emergency = 1'b0;
    logic       ns_left_req = 1'b0;
    logic       ew_left_req = 1'b0;
    logic [3:0] ns_out;
    logic [3:0] ew_out;
    logic       allstop;
    logic [2:0] phase;

    localparam logic [2:0] P_AR  = 3'd0;
    localparam logic [2:0] P_NSL = 3'd1;
    localparam logic [2:0] P_NSG = 3'd2;
    localparam logic [2:0] P_NSY = 3'd3;
    localparam logic [2:0] P_EWL = 3'd4;
    localparam logic [2:0] P_EWG = 3'd5;
    localparam logic [2:0] P_EWY = 3'd6;
    localparam logic [2:0] P_EM  = 3'd7;

    localparam logic [3:0] L_LEFT = 4'b1001;
    localparam logic [3:0] L_GRN  = 4'b0100;
    localparam logic [3:0] L_YEL  = 4'b0010;
    localparam logic [3:0] L_RED  = 4'b0001;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    intersection_controller #(
        .LEFT_T   (5),
        .GREEN_T  (10),
        .YELLOW_T (3),
        .CLEAR_T  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .emergency   (emergency),
        .ns_left_req (ns_left_req),
        .ew_left_req (ew_left_req),
        .ns_out      (ns_out),
        .ew_out      (ew_out),
        .allstop     (allstop),
        .phase       (phase)
    );

    // {ns_out, ew_out, allstop} expected for each phase
    function automatic logic [8:0] exp_out(input logic [2:0] ph);
        case (ph)
            P_NSL:   return {L_LEFT, L_RED, 1'b0};
            P_NSG:   return {L_GRN, L_RED, 1'b0};
            P_NSY:   return {L_YEL, L_RED, 1'b0};
            P_EWL:   return {L_RED, L_LEFT, 1'b0};
            P_EWG:   return {L_RED, L_GRN, 1'b0};
            P_EWY:   return {L_RED, L_YEL, 1'b0};
            P_EM:    return {L_RED, L_RED, 1'b1};
            default: return {L_RED, L_RED, 1'b0};
        endcase
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Expect n consecutive cycles in phase ph, each observed just after a rising edge.
    task automatic hold(input logic [2:0] ph, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            exp_q.push_back(ph);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] ph;
        logic [8:0] e;
        checks++;
        if (ns_out != L_RED && ew_out != L_RED) begin
            errors++;
            $display("FAIL safety: ns=%b ew=%b both non-red at %0t", ns_out, ew_out, $time);
        end
        if (exp_q.size() > 0) begin
            ph = exp_q.pop_front();
            e  = exp_out(ph);
            checks++;
            if ({phase, ns_out, ew_out, allstop} !== {ph, e}) begin
                errors++;
                $display("FAIL seq: got phase=%0d ns=%b ew=%b stop=%b expected phase=%0d ns=%b ew=%b stop=%b at %0t",
                         phase, ns_out, ew_out, allstop, ph, e[8:5], e[4:1], e[0], $time);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ns"}, {8'd0, ns_out}, {8'd0, L_RED});
        check({tag, "_ew"}, {8'd0, ew_out}, {8'd0, L_RED});
        check({tag, "_allstop"}, {11'd0, allstop}, 12'd0);
        check({tag, "_phase"}, {9'd0, phase}, {9'd0, P_AR});
    endtask

    task automatic basic_cycle();
        hold(P_AR, 1);
        hold(P_NSG, 10);
        hold(P_NSY, 3);
        hold(P_AR, 2);
        hold(P_EWG, 10);
        hold(P_EWY, 3);
        hold(P_AR, 2);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Free-running cycle, no requests
        basic_cycle();

        // EW left request during NS green
        hold(P_NSG, 3);
        ew_left_req = 1'b1;
        hold(P_NSG, 1);
        ew_left_req = 1'b0;
        hold(P_NSG, 6);
        hold(P_NSY, 3);
        hold(P_AR, 2);
        hold(P_EWL, 5);
        hold(P_EWG, 10);
        hold(P_EWY, 3);
        hold(P_AR, 2);
        hold(P_NSG, 10);
        hold(P_NSY, 3);
        hold(P_AR, 2);
        hold(P_EWG, 10);
        hold(P_EWY, 3);
        hold(P_AR, 2);

        // Emergency from NS green cycle 4, held for 8 samples
        hold(P_NSG, 4);
        emergency = 1'b1;
        hold(P_NSY, 3);
        hold(P_EM, 5);
        emergency = 1'b0;
        hold(P_AR, 2);
        hold(P_EWG, 10);
        hold(P_EWY, 3);

        // One-cycle pulse during all-red
        hold(P_AR, 1);
        emergency = 1'b1;
        hold(P_EM, 1);
        emergency = 1'b0;
        hold(P_AR, 2);
        hold(P_NSG, 10);
        hold(P_NSY, 3);
        hold(P_AR, 2);

        // Pulse during EW yellow cycle 1: yellow completes, then stop, then NS
        hold(P_EWG, 10);
        hold(P_EWY, 1);
        emergency = 1'b1;
        hold(P_EWY, 1);
        emergency = 1'b0;
        hold(P_EWY, 1);
        hold(P_EM, 1);
        hold(P_AR, 2);
        hold(P_NSG, 10);
        hold(P_NSY, 3);
        hold(P_AR, 2);

        // Asynchronous reset in the middle of EW green
        hold(P_EWG, 5);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        basic_cycle();

        @(negedge clk);
        #1;
        check("drain", 12'(exp_q.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
